// File: rtl/williams2_input_cond.sv
// Input conditioning for the williams2 core: synchronise and debounce the player inputs,
// resolve opposing directions, and shape coin presses into queued fixed-width pulses.
module williams2_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES   = 12000,
  parameter int unsigned COIN_PULSE_CYCLES = 600000,
  parameter int unsigned COIN_GAP_CYCLES   = 600000,
  parameter int unsigned COIN_QUEUE_MAX    = 3
) (
  input  logic       clock_12,
  input  logic       reset,
  input  logic [7:0] joy_in,
  input  logic [2:0] svc_in,
  output logic       btn_right,
  output logic       btn_left,
  output logic       btn_down,
  output logic       btn_up,
  output logic       btn_trigger,
  output logic       btn_start_1,
  output logic       btn_start_2,
  output logic       btn_coin,
  output logic       btn_auto_up,
  output logic       btn_advance,
  output logic       btn_high_score_reset,
  output logic [1:0] coin_pending
);

  localparam int unsigned NUM_IN  = 8;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                                    COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(COIN_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(COIN_GAP_CYCLES - 1);
  localparam logic [1:0]       QMAX       = 2'(COIN_QUEUE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_e;

  logic [NUM_IN-1:0] sync1_q, sync2_q;
  logic [2:0]        svc1_q, svc2_q;
  logic [NUM_IN-1:0] db_q, db_d;
  logic [CNT_W-1:0]  cnt_q [NUM_IN];
  logic [CNT_W-1:0]  cnt_d [NUM_IN];
  logic [6:0]        btn_q, btn_d;
  logic              coin_prev_q;
  logic              coin_rise;
  logic [1:0]        pending_q, pending_d;
  coin_state_e       state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              dequeue;
  logic              coin_q;

  // Two-flop synchronisers for player and service inputs.
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      svc1_q  <= '0;
      svc2_q  <= '0;
    end else begin
      sync1_q <= joy_in;
      sync2_q <= sync1_q;
      svc1_q  <= svc_in;
      svc2_q  <= svc1_q;
    end
  end

  // Per-bit debounce: a change is accepted after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Opposing directions cancel each other out.
  always_comb begin
    btn_d      = db_q[6:0];
    btn_d[0]   = db_q[0] & ~db_q[1];
    btn_d[1]   = db_q[1] & ~db_q[0];
    btn_d[2]   = db_q[2] & ~db_q[3];
    btn_d[3]   = db_q[3] & ~db_q[2];
  end

  assign coin_rise = db_q[7] & ~coin_prev_q;

  // Coin pulse sequencer; a dequeue can only happen from IDLE.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dequeue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q != 2'd0) begin
          state_d = PULSE;
          tmr_d   = PULSE_LOAD;
          dequeue = 1'b1;
        end
      end
      PULSE: begin
        if (tmr_q == '0) begin
          state_d = GAP;
          tmr_d   = GAP_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      GAP: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Simultaneous enqueue and dequeue leave the depth unchanged, even when saturated.
  always_comb begin
    pending_d = pending_q;
    if (coin_rise && !dequeue) begin
      if (pending_q != QMAX) begin
        pending_d = pending_q + 2'd1;
      end
    end else if (!coin_rise && dequeue) begin
      pending_d = pending_q - 2'd1;
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      btn_q       <= '0;
      coin_prev_q <= 1'b0;
      pending_q   <= '0;
      state_q     <= IDLE;
      tmr_q       <= '0;
      coin_q      <= 1'b0;
    end else begin
      btn_q       <= btn_d;
      coin_prev_q <= db_q[7];
      pending_q   <= pending_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      coin_q      <= (state_d == PULSE);
    end
  end

  assign btn_right            = btn_q[0];
  assign btn_left             = btn_q[1];
  assign btn_down             = btn_q[2];
  assign btn_up               = btn_q[3];
  assign btn_trigger          = btn_q[4];
  assign btn_start_1          = btn_q[5];
  assign btn_start_2          = btn_q[6];
  assign btn_coin             = coin_q;
  assign btn_auto_up          = svc2_q[0];
  assign btn_advance          = svc2_q[1];
  assign btn_high_score_reset = svc2_q[2];
  assign coin_pending         = pending_q;

endmodule
